uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame and width of Rx_Data.
REQ-002 Parameter OVERSAMPLE, default 16, sample ticks per bit period; SHALL be even and at least 4.
REQ-003 Parameter CLKS_PER_TICK, default 27, clk cycles per sample tick; SHALL be at least 1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 Rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 BIST_Mode  input  1  when 1, receiver is held idle.
REQ-008 Rx_Data  output  DATA_BITS  last correctly received word.
REQ-009 Data_Rdy  output  1  one-cycle pulse when a new word is valid on Rx_Data; drives the downstream FIFO write strobe.
REQ-010 Framing_Err  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 Rx_Busy  output  1  high in every state except IDLE.

Function
REQ-012 Rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s), giving 2 clk of input latency.
REQ-013 A tick generator SHALL pulse for one clk every CLKS_PER_TICK clks and restart from 0 when IDLE is left.
REQ-014 FSM states: IDLE, START, DATA, STOP, plus PARITY when the parity option is compiled in.
REQ-015 IDLE -> START on a falling edge of rx_s (previous 1, current 0); the tick counter clears.
REQ-016 START: at tick OVERSAMPLE/2-1 sample rx_s; 0 -> DATA; 1 -> IDLE as a false start, with no output pulse.
REQ-017 DATA: sample rx_s every OVERSAMPLE ticks at the bit centre; shift in LSB first; after DATA_BITS samples -> STOP, or -> PARITY if compiled in.
REQ-018 STOP: sample at the bit centre; 1 -> load Rx_Data from the shift register and pulse Data_Rdy the next clk; 0 -> pulse Framing_Err the next clk and leave Rx_Data unchanged.
REQ-019 After STOP the FSM returns to IDLE at the same stop-bit centre sample; a new start bit is accepted only after rx_s has been seen high.
REQ-020 Rx_Data SHALL hold its value between Data_Rdy pulses; Data_Rdy and Framing_Err are never high in the same cycle.
REQ-021 BIST_Mode = 1 forces IDLE within 1 clk, aborts any frame in progress with no Data_Rdy, and suppresses start detection while held.
REQ-022 Bit counter width is $clog2(DATA_BITS+1); tick counter width is $clog2(OVERSAMPLE); both wrap only under FSM control.

Reset
REQ-023 rst = 0 asynchronously sets: state IDLE, Rx_Data 0, Data_Rdy 0, Framing_Err 0, Rx_Busy 0, all counters 0, synchronizer flops 1.
REQ-024 Deasserting rst mid-frame SHALL start from IDLE; the line must be seen high before a start bit is accepted.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: PARITY state samples an even-parity bit after the data bits, and an extra output Parity_Err (1 bit) is added.
REQ-026 With the macro defined, a parity mismatch SHALL pulse Parity_Err in the same cycle Data_Rdy would pulse; Data_Rdy is suppressed and Rx_Data is not updated.
REQ-027 Macro undefined: no PARITY state and no Parity_Err port; the frame is start + DATA_BITS + stop.

Structure
REQ-028 Package uart_pkg SHALL hold the rx_state_t enum and the default OVERSAMPLE constant, shared with the transmitter and the FIFO bench.
REQ-029 The tick generator SHALL be a sub-module, uart_baud_gen (inputs: clk, rst, clear; output: tick); everything else stays in uart_rx.

Verification (CLKS_PER_TICK=2, OVERSAMPLE=16, DATA_BITS=8)
REQ-030 Send frame 0xA5 with a valid stop bit -> exactly one Data_Rdy pulse, Rx_Data=0xA5, Framing_Err never high.
REQ-031 Drive Rx low for 4 ticks, then high -> back in IDLE, no Data_Rdy, no Framing_Err, Rx_Busy low within 10 ticks.
REQ-032 Send 0x3C with the stop bit low -> one Framing_Err pulse, Rx_Data keeps its previous value (0xA5).
REQ-033 Send 0x00 then 0xFF back-to-back with a single stop bit each -> two Data_Rdy pulses with Rx_Data 0x00, then 0xFF.
REQ-034 Assert rst or BIST_Mode in the middle of data bit 4 of 0x5A -> no Data_Rdy; Rx_Busy goes low; the next frame 0x5A is received correctly.
REQ-035 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> Parity_Err pulse, no Data_Rdy; send 0x07 with parity bit 1 -> Data_Rdy, Rx_Data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver, transmitter and FIFO bench.
//   rx_state_t         - receiver FSM state encoding
//   OVERSAMPLE_DEFAULT - default number of sample ticks per bit period
// Optional feature macro: UART_RX_PARITY_EN (adds the StParity state).

package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: sample-tick generator for the UART receiver.
//   clk   - clock
//   rst   - asynchronous active-low reset
//   clear - holds the divider at 0 (no ticks) while high
//   tick  - one-clk pulse every CLKS_PER_TICK clks while clear is low

module uart_baud_gen #(
    parameter int unsigned CLKS_PER_TICK = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_TICK - 1);

    logic [CntW-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == CntMax);
    assign tick   = w_wrap && !clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start + DATA_BITS LSB-first + stop).
//   clk         - clock
//   rst         - asynchronous active-low reset
//   Rx          - serial line, asynchronous, idle high
//   BIST_Mode   - holds the receiver idle and aborts any frame in progress
//   Rx_Data     - last correctly received word, held between Data_Rdy pulses
//   Data_Rdy    - one-clk pulse when Rx_Data carries a new word
//   Framing_Err - one-clk pulse when the stop bit samples low
//   Rx_Busy     - high whenever the FSM is not idle
//   Parity_Err  - (UART_RX_PARITY_EN only) one-clk pulse on an even-parity mismatch
// Optional feature macro: UART_RX_PARITY_EN (even-parity bit between data and stop).

module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned OVERSAMPLE    = OVERSAMPLE_DEFAULT,
    parameter int unsigned CLKS_PER_TICK = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx,
    input  logic                 BIST_Mode,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Data_Rdy,
    output logic                 Framing_Err,
`ifdef UART_RX_PARITY_EN
    output logic                 Parity_Err,
`endif
    output logic                 Rx_Busy
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
    localparam logic [TickW-1:0] HalfM1  = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] FullM1  = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  LastBit = BitW'(DATA_BITS - 1);

    rx_state_t r_state, w_state_d;

    logic                 r_rx_meta, r_rx_s, r_rx_prev;
    logic [TickW-1:0]     r_tick_cnt;
    logic [BitW-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_data_rdy, r_frm_err;
    logic                 w_tick, w_clear, w_sample, w_fall, w_stop_smp;
    logic                 w_data_rdy_d, w_frm_err_d;
    logic [TickW-1:0]     w_sample_pt;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit, r_par_err, w_par_err_d, w_par_ok;
`endif

    // Synchronizer plus one more flop for falling-edge detection. Reset high so the
    // line counts as idle; a start needs a real high-to-low transition of rx_s.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= Rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_fall  = r_rx_prev && !r_rx_s;
    assign w_clear = (r_state == StIdle);

    uart_baud_gen #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(w_clear),
        .tick (w_tick)
    );

    // START samples half a bit after the edge; later states sample one full bit later.
    assign w_sample_pt = (r_state == StStart) ? HalfM1 : FullM1;
    assign w_sample    = w_tick && (r_tick_cnt == w_sample_pt);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   if (w_fall) w_state_d = StStart;
            StStart:  if (w_sample) w_state_d = r_rx_s ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
            StData:   if (w_sample && r_bit_cnt == LastBit) w_state_d = StParity;
            StParity: if (w_sample) w_state_d = StStop;
`else
            StData:   if (w_sample && r_bit_cnt == LastBit) w_state_d = StStop;
`endif
            StStop:   if (w_sample) w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
        if (BIST_Mode) w_state_d = StIdle;
    end

    // Output logic: next values of the registered pulses, plus the busy flag
    always_comb begin
        w_stop_smp  = (r_state == StStop) && w_sample && !BIST_Mode;
        w_frm_err_d = w_stop_smp && !r_rx_s;
`ifdef UART_RX_PARITY_EN
        // Even parity: data bits plus parity bit carry an even number of ones.
        w_par_ok     = ~(^{r_shift, r_par_bit});
        w_data_rdy_d = w_stop_smp && r_rx_s && w_par_ok;
        w_par_err_d  = w_stop_smp && r_rx_s && !w_par_ok;
`else
        w_data_rdy_d = w_stop_smp && r_rx_s;
`endif
        Rx_Busy = (r_state != StIdle);
    end

    // Sample/bit counters and shift register; cleared whenever the FSM is (or is forced) idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bit  <= 1'b0;
`endif
        end else if (r_state == StIdle || BIST_Mode) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_tick) begin
            if (w_sample) begin
                r_tick_cnt <= '0;
                if (r_state == StData) begin
                    r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                    r_bit_cnt <= r_bit_cnt + BitW'(1);
                end
`ifdef UART_RX_PARITY_EN
                if (r_state == StParity) r_par_bit <= r_rx_s;
`endif
            end else begin
                r_tick_cnt <= r_tick_cnt + TickW'(1);
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_data  <= '0;
            r_data_rdy <= 1'b0;
            r_frm_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err  <= 1'b0;
`endif
        end else begin
            r_data_rdy <= w_data_rdy_d;
            r_frm_err  <= w_frm_err_d;
`ifdef UART_RX_PARITY_EN
            r_par_err  <= w_par_err_d;
`endif
            if (w_data_rdy_d) r_rx_data <= r_shift;
        end
    end

    assign Rx_Data     = r_rx_data;
    assign Data_Rdy    = r_data_rdy;
    assign Framing_Err = r_frm_err;
`ifdef UART_RX_PARITY_EN
    assign Parity_Err  = r_par_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (DATA_BITS=8, OVERSAMPLE=16, CLKS_PER_TICK=2).
// Frames are driven bit by bit; a frame-level model predicts each frame's outcome.
// Also exercises the UART_RX_PARITY_EN build when that macro is defined.

module tb_uart_rx;

    localparam int BIT_CLKS = 32;  // OVERSAMPLE * CLKS_PER_TICK
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Rx = 1'b1;
    logic       BIST_Mode = 1'b0;
    logic [7:0] Rx_Data;
    logic       Data_Rdy, Framing_Err, Rx_Busy;
`ifdef UART_RX_PARITY_EN
    logic       Parity_Err;
`endif

    uart_rx #(
        .DATA_BITS    (8),
        .OVERSAMPLE   (16),
        .CLKS_PER_TICK(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Rx         (Rx),
        .BIST_Mode  (BIST_Mode),
        .Rx_Data    (Rx_Data),
        .Data_Rdy   (Data_Rdy),
        .Framing_Err(Framing_Err),
`ifdef UART_RX_PARITY_EN
        .Parity_Err (Parity_Err),
`endif
        .Rx_Busy    (Rx_Busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] rdy_q[$];
    int         fe_cnt = 0, pe_cnt = 0, busy_cnt = 0, viol = 0;
    int         exp_fe = 0, exp_pe = 0;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] last_data = 8'h00;

    // Output monitor: records pulses and checks the hold / exclusivity rules every cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (Data_Rdy) rdy_q.push_back(Rx_Data);
            if (Framing_Err) fe_cnt++;
            if (Rx_Busy) busy_cnt++;
            if (Data_Rdy && Framing_Err) viol++;
            if (!Data_Rdy && Rx_Data !== last_data) viol++;
`ifdef UART_RX_PARITY_EN
            if (Parity_Err) pe_cnt++;
            if (Parity_Err && (Data_Rdy || Framing_Err)) viol++;
`endif
        end
        last_data = Rx_Data;
    end

    initial begin
        #600000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int clks);
        Rx = b;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_par);
        send_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLKS);
        if (PAR_EN) send_bit((^d) ^ bad_par, BIT_CLKS);
        send_bit(stop_b, BIT_CLKS);
        Rx = 1'b1;
    endtask

    // Frame-level model: good stop and parity -> one word; bad stop -> framing error;
    // bad parity (parity build only) -> parity error; Rx_Data changes only on a good word.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic stop_b,
                             input logic bad_par);
        logic good;
        good = stop_b && !(PAR_EN && bad_par);
        send_frame(d, stop_b, bad_par);
        if (!stop_b) exp_fe++;
        else if (PAR_EN && bad_par) exp_pe++;
        check({tag, " rdy_count"}, 32'(rdy_q.size()), good ? 32'd1 : 32'd0);
        if (good) begin
            exp_data = d;
            if (rdy_q.size() != 0) check({tag, " rdy_data"}, 32'(rdy_q[0]), 32'(d));
        end
        check({tag, " fe_count"}, 32'(fe_cnt), 32'(exp_fe));
`ifdef UART_RX_PARITY_EN
        check({tag, " pe_count"}, 32'(pe_cnt), 32'(exp_pe));
`endif
        check({tag, " rx_data"}, 32'(Rx_Data), 32'(exp_data));
        rdy_q.delete();
    endtask

    // Start + nbits data bits + half of the next data bit.
    task automatic send_partial(input logic [7:0] d, input int nbits);
        send_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < nbits; i++) send_bit(d[i], BIT_CLKS);
        send_bit(d[nbits], BIT_CLKS / 2);
    endtask

    initial begin
        logic [7:0] d;
        logic       stop_b, bad_par;
        int         gap, waited;

        // Reset state
        repeat (4) @(negedge clk);
        check("reset rx_data", 32'(Rx_Data), 32'h0);
        check("reset data_rdy", 32'(Data_Rdy), 32'h0);
        check("reset framing_err", 32'(Framing_Err), 32'h0);
        check("reset rx_busy", 32'(Rx_Busy), 32'h0);
        rst = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);

        // Good frame
        run_frame("a5", 8'hA5, 1'b1, 1'b0);

        // False start: low for 4 ticks (8 clks), then high
        Rx = 1'b0;
        repeat (6) @(negedge clk);
        check("false_start busy_high", 32'(Rx_Busy), 32'h1);
        repeat (2) @(negedge clk);
        Rx = 1'b1;
        waited = 0;
        while (Rx_Busy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("false_start busy_low", 32'(Rx_Busy), 32'h0);
        repeat (BIT_CLKS) @(negedge clk);
        check("false_start no_rdy", 32'(rdy_q.size()), 32'h0);
        check("false_start no_fe", 32'(fe_cnt), 32'(exp_fe));

        // Bad stop bit: framing error, data held
        run_frame("3c_badstop", 8'h3C, 1'b0, 1'b0);
        send_bit(1'b1, BIT_CLKS);

        // Back-to-back frames
        run_frame("b2b_00", 8'h00, 1'b1, 1'b0);
        run_frame("b2b_ff", 8'hFF, 1'b1, 1'b0);
        send_bit(1'b1, BIT_CLKS);

        // Reset in the middle of data bit 4
        send_partial(8'h5A, 4);
        rst = 1'b0;
        @(negedge clk);
        check("rst_abort busy", 32'(Rx_Busy), 32'h0);
        check("rst_abort rx_data", 32'(Rx_Data), 32'h0);
        exp_data = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        send_bit(1'b1, 2 * BIT_CLKS);
        check("rst_abort no_rdy", 32'(rdy_q.size()), 32'h0);
        run_frame("rst_next_5a", 8'h5A, 1'b1, 1'b0);
        send_bit(1'b1, BIT_CLKS);

        // BIST in the middle of data bit 4
        send_partial(8'h5A, 4);
        BIST_Mode = 1'b1;
        @(negedge clk);
        check("bist_abort busy", 32'(Rx_Busy), 32'h0);
        repeat (3) @(negedge clk);
        BIST_Mode = 1'b0;
        send_bit(1'b1, 2 * BIT_CLKS);
        check("bist_abort no_rdy", 32'(rdy_q.size()), 32'h0);
        check("bist_abort rx_data", 32'(Rx_Data), 32'(exp_data));
        run_frame("bist_next_5a", 8'h5A, 1'b1, 1'b0);
        send_bit(1'b1, BIT_CLKS);

        // BIST held through a whole frame: nothing starts
        BIST_Mode = 1'b1;
        busy_cnt = 0;
        send_frame(8'h33, 1'b1, 1'b0);
        send_bit(1'b1, BIT_CLKS);
        check("bist_hold busy_cycles", 32'(busy_cnt), 32'h0);
        check("bist_hold no_rdy", 32'(rdy_q.size()), 32'h0);
        BIST_Mode = 1'b0;
        send_bit(1'b1, BIT_CLKS);

`ifdef UART_RX_PARITY_EN
        run_frame("par_07_bad", 8'h07, 1'b1, 1'b1);
        run_frame("par_07_good", 8'h07, 1'b1, 1'b0);
        send_bit(1'b1, BIT_CLKS);
`endif

        // Random frames with random gaps, bad stop bits and bad parity
        for (int k = 0; k < 12; k++) begin
            d       = 8'($urandom_range(0, 255));
            stop_b  = ($urandom_range(0, 3) != 0);
            bad_par = ($urandom_range(0, 3) == 0);
            run_frame($sformatf("rand%0d", k), d, stop_b, bad_par);
            gap = $urandom_range(0, 40);
            if (!stop_b) gap = gap + 4;  // line must be seen high before the next start
            if (gap > 0) send_bit(1'b1, gap);
        end

        send_bit(1'b1, BIT_CLKS);
        check("final no_stray_rdy", 32'(rdy_q.size()), 32'h0);
        check("hold_exclusive_rules", 32'(viol), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
